id_token_scanner: RTL and testbench

- Parametrised successor to the single-bit identifier recognizer.
- Scans a byte-wide ASCII character stream, one character per valid cycle.
- Tracks identifier tokens: one or more letters followed by a run of digits.
- Reports a live match flag, token length, trailing-digit count, an end-of-token pulse and a saturating match counter.
- Sits between the character source (UART/test stimulus) and result-display/count logic.

---
 rtl/id_token_if.sv | 24 ++
 rtl/id_token_scanner.sv | 110 +++++++++++
 tb/tb_id_token_scanner.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_token_if.sv
// Character-stream bus for id_token_scanner: the source drives char_valid/char,
// and the scanner returns its token-tracking results.
interface id_token_if #(
  parameter int LEN_W = 6,
  parameter int CNT_W = 8
);
  logic             char_valid;
  logic [7:0]       char;
  logic             out;
  logic [LEN_W-1:0] tok_len;
  logic [LEN_W-1:0] digit_cnt;
  logic             tok_end;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output char_valid, char,
    input  out, tok_len, digit_cnt, tok_end, match_cnt
  );

  modport slave (
    input  char_valid, char,
    output out, tok_len, digit_cnt, tok_end, match_cnt
  );
endinterface

// File: rtl/id_token_scanner.sv
// Identifier token scanner: letters followed by a digit run, with length limit,
// end-of-token pulse and saturating match counter. Optional macro: ID_UNDERSCORE_EN.
module id_token_scanner #(
  parameter int MAX_LEN    = 32,
  parameter int LEN_W      = 6,
  parameter int MIN_DIGITS = 1,
  parameter int CNT_W      = 8
) (
  input  logic     clk,
  input  logic     reset,
  id_token_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ALPHA, S_DIGIT, S_OVF} state_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_D = LEN_W'(MIN_DIGITS);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] tok_len_reg, tok_len_next;
  logic [LEN_W-1:0] digit_cnt_reg, digit_cnt_next;
  logic             tok_end_reg, tok_end_next;
  logic [CNT_W-1:0] match_cnt_reg, match_cnt_next;

  logic is_letter, is_digit, is_alnum, out_w;

  always_comb begin
    is_letter = ((bus.char >= 8'h61) && (bus.char <= 8'h7A)) ||
                ((bus.char >= 8'h41) && (bus.char <= 8'h5A));
`ifdef ID_UNDERSCORE_EN
    if (bus.char == 8'h5F) is_letter = 1'b1;
`else
    // Underscore falls through to the delimiter class like a space.
`endif
    is_digit = (bus.char >= 8'h30) && (bus.char <= 8'h39);
    is_alnum = is_letter || is_digit;
  end

  assign out_w = (state_reg == S_DIGIT) && (digit_cnt_reg >= MIN_D);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      tok_len_reg   <= '0;
      digit_cnt_reg <= '0;
      tok_end_reg   <= 1'b0;
      match_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      tok_len_reg   <= tok_len_next;
      digit_cnt_reg <= digit_cnt_next;
      tok_end_reg   <= tok_end_next;
      match_cnt_reg <= match_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tok_len_next   = tok_len_reg;
    digit_cnt_next = digit_cnt_reg;
    tok_end_next   = 1'b0;
    match_cnt_next = match_cnt_reg;
    if (bus.char_valid) begin
      if (!is_alnum) begin
        state_next     = S_IDLE;
        tok_len_next   = '0;
        digit_cnt_next = '0;
        if (out_w) begin
          tok_end_next = 1'b1;
          if (match_cnt_reg != '1) match_cnt_next = match_cnt_reg + ONE_C;
        end
      end else begin
        unique case (state_reg)
          S_IDLE: begin
            // A leading digit is skipped; only a letter opens a token.
            if (is_letter) begin
              state_next     = S_ALPHA;
              tok_len_next   = ONE_L;
              digit_cnt_next = '0;
            end
          end
          S_ALPHA, S_DIGIT: begin
            if (tok_len_reg == MAX_L) begin
              state_next = S_OVF;
            end else begin
              tok_len_next = tok_len_reg + ONE_L;
              if (is_letter) begin
                state_next     = S_ALPHA;
                digit_cnt_next = '0;
              end else begin
                state_next     = S_DIGIT;
                digit_cnt_next = digit_cnt_reg + ONE_L;
              end
            end
          end
          default: begin
            // Over-long token: counters stay frozen until a delimiter.
          end
        endcase
      end
    end
  end

  assign bus.out       = out_w;
  assign bus.tok_len   = tok_len_reg;
  assign bus.digit_cnt = digit_cnt_reg;
  assign bus.tok_end   = tok_end_reg;
  assign bus.match_cnt = match_cnt_reg;
endmodule

// File: tb/tb_id_token_scanner.sv
// Bench for id_token_scanner: four parameter variants share one character stream
// and are compared against a token-buffer reference model, plus constant vectors.
module tb_id_token_scanner;
  logic clk;
  logic reset;
  logic v;
  logic [7:0] c;

  int checks = 0;
  int errors = 0;
  int ntx = 0;

  // Variants: 0 default, 1 MAX_LEN=4, 2 MIN_DIGITS=2, 3 CNT_W=2
  int maxl[4] = '{32, 4, 32, 32};
  int mind[4] = '{1, 1, 2, 1};
  int cntw[4] = '{8, 8, 8, 2};

  id_token_if #(.LEN_W(6), .CNT_W(8)) if0 ();
  id_token_if #(.LEN_W(6), .CNT_W(8)) if1 ();
  id_token_if #(.LEN_W(6), .CNT_W(8)) if2 ();
  id_token_if #(.LEN_W(6), .CNT_W(2)) if3 ();

  assign if0.char_valid = v;  assign if0.char = c;
  assign if1.char_valid = v;  assign if1.char = c;
  assign if2.char_valid = v;  assign if2.char = c;
  assign if3.char_valid = v;  assign if3.char = c;

  id_token_scanner #(.MAX_LEN(32), .LEN_W(6), .MIN_DIGITS(1), .CNT_W(8))
    dut0 (.clk(clk), .reset(reset), .bus(if0));
  id_token_scanner #(.MAX_LEN(4), .LEN_W(6), .MIN_DIGITS(1), .CNT_W(8))
    dut1 (.clk(clk), .reset(reset), .bus(if1));
  id_token_scanner #(.MAX_LEN(32), .LEN_W(6), .MIN_DIGITS(2), .CNT_W(8))
    dut2 (.clk(clk), .reset(reset), .bus(if2));
  id_token_scanner #(.MAX_LEN(32), .LEN_W(6), .MIN_DIGITS(1), .CNT_W(2))
    dut3 (.clk(clk), .reset(reset), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: the characters of the live token, an overflow flag,
  // the registered tok_end pulse and the match count.
  byte unsigned tq [4][$];
  bit ovf [4];
  bit tend [4];
  int mcnt [4];

  function automatic bit m_letter(input byte unsigned ch);
`ifdef ID_UNDERSCORE_EN
    if (ch == 8'h5F) return 1'b1;
`endif
    return (ch >= 8'd97 && ch <= 8'd122) || (ch >= 8'd65 && ch <= 8'd90);
  endfunction

  function automatic bit m_digit(input byte unsigned ch);
    return ch >= 8'd48 && ch <= 8'd57;
  endfunction

  function automatic int m_trail(input int i);
    int n = 0;
    for (int k = tq[i].size() - 1; k >= 0; k--) begin
      if (m_digit(tq[i][k])) n++;
      else break;
    end
    return n;
  endfunction

  function automatic bit m_out(input int i);
    return !ovf[i] && (m_trail(i) >= mind[i]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      tq[i].delete();
      ovf[i] = 1'b0;
      tend[i] = 1'b0;
      mcnt[i] = 0;
    end
  endtask

  task automatic m_step(input int i, input bit vv, input byte unsigned ch);
    bit was_out;
    was_out = m_out(i);
    tend[i] = 1'b0;
    if (vv) begin
      if (m_letter(ch) || m_digit(ch)) begin
        if (ovf[i]) begin
        end else if (tq[i].size() == 0 && m_digit(ch)) begin
        end else if (tq[i].size() == maxl[i]) begin
          ovf[i] = 1'b1;
        end else begin
          tq[i].push_back(ch);
        end
      end else begin
        if (was_out) begin
          tend[i] = 1'b1;
          if (mcnt[i] < (1 << cntw[i]) - 1) mcnt[i]++;
        end
        tq[i].delete();
        ovf[i] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (txn %0d)", name, act, exp, ntx);
    end
  endtask

  task automatic chk_dut(input int i, input int o, input int tl, input int dc,
                         input int te, input int mc);
    chk($sformatf("d%0d.out", i), o, int'(m_out(i)));
    chk($sformatf("d%0d.tok_len", i), tl, tq[i].size());
    chk($sformatf("d%0d.digit_cnt", i), dc, m_trail(i));
    chk($sformatf("d%0d.tok_end", i), te, int'(tend[i]));
    chk($sformatf("d%0d.match_cnt", i), mc, mcnt[i]);
  endtask

  task automatic check_all();
    chk_dut(0, int'(if0.out), int'(if0.tok_len), int'(if0.digit_cnt), int'(if0.tok_end), int'(if0.match_cnt));
    chk_dut(1, int'(if1.out), int'(if1.tok_len), int'(if1.digit_cnt), int'(if1.tok_end), int'(if1.match_cnt));
    chk_dut(2, int'(if2.out), int'(if2.tok_len), int'(if2.digit_cnt), int'(if2.tok_end), int'(if2.match_cnt));
    chk_dut(3, int'(if3.out), int'(if3.tok_len), int'(if3.digit_cnt), int'(if3.tok_end), int'(if3.match_cnt));
  endtask

  task automatic cyc(input bit vv, input byte unsigned ch);
    v = vv;
    c = ch;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) m_step(i, vv, ch);
    ntx++;
    check_all();
    $display("txn %0d v=%0d ch=%02h d0:out=%0d len=%0d dig=%0d end=%0d cnt=%0d",
             ntx, vv, ch, if0.out, if0.tok_len, if0.digit_cnt, if0.tok_end, if0.match_cnt);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v = 1'b1;
    c = 8'h61;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_reset();
    ntx++;
    check_all();
    $display("txn %0d reset", ntx);
  endtask

  task automatic feed(input string s);
    for (int k = 0; k < s.len(); k++) cyc(1'b1, s[k]);
  endtask

  typedef struct {
    bit          vv;
    byte unsigned ch;
    int          e_out;
    int          e_len;
    int          e_dig;
    int          e_end;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    reset = 1'b0;
    v = 1'b0;
    c = 8'h00;
    m_reset();
    // Expected values for the default variant, written from the token rules.
    tbl.push_back('{1'b1, 8'h61, 0, 1, 0, 0, 0});  // a
    tbl.push_back('{1'b1, 8'h62, 0, 2, 0, 0, 0});  // b
    tbl.push_back('{1'b1, 8'h31, 1, 3, 1, 0, 0});  // 1
    tbl.push_back('{1'b1, 8'h32, 1, 4, 2, 0, 0});  // 2
    tbl.push_back('{1'b1, 8'h20, 0, 0, 0, 1, 1});  // ' ' ends a match
    tbl.push_back('{1'b0, 8'h20, 0, 0, 0, 0, 1});  // idle: pulse drops
    tbl.push_back('{1'b1, 8'h39, 0, 0, 0, 0, 1});  // 9 leading digit
    tbl.push_back('{1'b1, 8'h61, 0, 1, 0, 0, 1});  // a
    tbl.push_back('{1'b1, 8'h20, 0, 0, 0, 0, 1});  // ' ' no match
    tbl.push_back('{1'b1, 8'h61, 0, 1, 0, 0, 1});  // a
    tbl.push_back('{1'b1, 8'h62, 0, 2, 0, 0, 1});  // b
    tbl.push_back('{1'b1, 8'h20, 0, 0, 0, 0, 1});  // ' '
    tbl.push_back('{1'b1, 8'h20, 0, 0, 0, 0, 1});  // consecutive delimiter
    tbl.push_back('{1'b1, 8'h61, 0, 1, 0, 0, 1});  // a
    tbl.push_back('{1'b1, 8'h62, 0, 2, 0, 0, 1});  // b
    tbl.push_back('{1'b1, 8'h31, 1, 3, 1, 0, 1});  // 1
    tbl.push_back('{1'b1, 8'h63, 0, 4, 0, 0, 1});  // c restarts digit run
    tbl.push_back('{1'b1, 8'h2E, 0, 0, 0, 0, 1});  // '.' no tok_end

    do_reset();
    chk("reset.out", int'(if0.out), 0);
    chk("reset.cnt", int'(if0.match_cnt), 0);

    for (int k = 0; k < tbl.size(); k++) begin
      cyc(tbl[k].vv, tbl[k].ch);
      chk($sformatf("tbl%0d.out", k), int'(if0.out), tbl[k].e_out);
      chk($sformatf("tbl%0d.len", k), int'(if0.tok_len), tbl[k].e_len);
      chk($sformatf("tbl%0d.dig", k), int'(if0.digit_cnt), tbl[k].e_dig);
      chk($sformatf("tbl%0d.end", k), int'(if0.tok_end), tbl[k].e_end);
      chk($sformatf("tbl%0d.cnt", k), int'(if0.match_cnt), tbl[k].e_cnt);
    end

    // "a1b2 " with char_valid toggling; invalid cycles carry junk characters.
    do_reset();
    cyc(1'b1, "a");  cyc(1'b0, "7");
    cyc(1'b1, "1");  chk("tog.out_1", int'(if0.out), 1);
    cyc(1'b0, " ");  chk("tog.hold_out", int'(if0.out), 1);
    chk("tog.hold_len", int'(if0.tok_len), 2);
    chk("tog.hold_end", int'(if0.tok_end), 0);
    cyc(1'b1, "b");  chk("tog.out_b", int'(if0.out), 0);
    cyc(1'b0, "z");
    cyc(1'b1, "2");  chk("tog.out_2", int'(if0.out), 1);
    cyc(1'b0, "3");
    cyc(1'b1, " ");  chk("tog.end", int'(if0.tok_end), 1);
    cyc(1'b0, "x");  chk("tog.end_once", int'(if0.tok_end), 0);
    chk("tog.cnt", int'(if0.match_cnt), 1);

    // MAX_LEN=4: "abc12 " overflows on '2' and never counts.
    do_reset();
    feed("abc12");
    chk("ovf.state_out", int'(if1.out), 0);
    chk("ovf.len", int'(if1.tok_len), 4);
    feed(" ");
    chk("ovf.end", int'(if1.tok_end), 0);
    chk("ovf.cnt", int'(if1.match_cnt), 0);

    // MIN_DIGITS=2: "x1 x12 ".
    do_reset();
    feed("x1 ");
    chk("min2.end1", int'(if2.tok_end), 0);
    feed("x12 ");
    chk("min2.end2", int'(if2.tok_end), 1);
    chk("min2.cnt", int'(if2.match_cnt), 1);

    // CNT_W=2 saturates at 3, then reset mid-token.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      feed("a1 ");
      chk($sformatf("sat.cnt%0d", t), int'(if3.match_cnt), (t < 3) ? t + 1 : 3);
    end
    feed("a1");
    chk("rst.pre_out", int'(if3.out), 1);
    do_reset();
    chk("rst.out", int'(if3.out), 0);
    chk("rst.end", int'(if3.tok_end), 0);
    chk("rst.cnt", int'(if3.match_cnt), 0);
    chk("rst.len", int'(if3.tok_len), 0);

    // Long token pushes the default variant into overflow.
    for (int k = 0; k < 40; k++) cyc(1'b1, "q");
    chk("long.len", int'(if0.tok_len), 32);
    feed("12 ");
    chk("long.end", int'(if0.tok_end), 0);

    // Randomized stream against the model.
    for (int n = 0; n < 1500; n++) begin
      int k;
      byte unsigned ch;
      bit vv;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        vv = ($urandom_range(0, 3) != 0);
        k = $urandom_range(0, 9);
        if (k < 3)       ch = 8'(97 + $urandom_range(0, 25));
        else if (k == 3) ch = 8'(65 + $urandom_range(0, 25));
        else if (k < 7)  ch = 8'(48 + $urandom_range(0, 9));
        else if (k == 7) ch = 8'h20;
        else if (k == 8) ch = 8'h5F;
        else             ch = 8'($urandom_range(0, 255));
        cyc(vv, ch);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
